game_screen_ctrl: RTL and testbench

- Display/game-flow controller directly downstream of You_Win_Top.
- Consumes its 12-bit win-screen pixel and score-reached flag, plus the game-scene pixel and DTG timing.
- Runs the IDLE/PLAY/WIN/RESTART flow, selects the final 12-bit VGA colour, and issues a one-cycle game reset that clears score and sprites.

---
 rtl/game_screen_ctrl_if.sv | 25 ++
 rtl/game_screen_ctrl.sv | 161 ++++++++++++++++
 tb/tb_game_screen_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/game_screen_ctrl_if.sv
// Signal bundle between the DTG/You_Win_Top side and game_screen_ctrl.
// The controller sits on the slave side; the master side drives timing, pixels and buttons.
interface game_screen_ctrl_if;
    logic [9:0]  pix_row;
    logic [9:0]  pix_col;
    logic        video_on;
    logic [11:0] game_pixel;
    logic [11:0] you_win_pixel;
    logic        win_flag;
    logic        start_btn;
    logic [11:0] vga_rgb;
    logic        game_run;
    logic        game_reset;
    logic [1:0]  state_out;

    modport master (
        output pix_row, pix_col, video_on, game_pixel, you_win_pixel, win_flag, start_btn,
        input  vga_rgb, game_run, game_reset, state_out
    );

    modport slave (
        input  pix_row, pix_col, video_on, game_pixel, you_win_pixel, win_flag, start_btn,
        output vga_rgb, game_run, game_reset, state_out
    );
endinterface

// File: rtl/game_screen_ctrl.sv
// Game-flow controller: IDLE/PLAY/WIN/RESTART sequencing, final VGA colour selection
// and the one-cycle game reset pulse that clears score and sprites.
module game_screen_ctrl #(
    parameter int PIX_DLY         = 3,
    parameter int WIN_HOLD_FRAMES = 180,
    parameter int FRAME_CNT_W     = 8
) (
    input logic              clk,
    input logic              reset,
    game_screen_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        WIN     = 2'd2,
        RESTART = 2'd3
    } state_t;

    localparam logic [FRAME_CNT_W-1:0] HOLD_LAST = FRAME_CNT_W'(WIN_HOLD_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] CNT_MAX   = '1;

    state_t                 state;
    state_t                 next_state;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   cnt_clear;
    logic                   cnt_inc;

    logic [11:0]            pix_pipe [PIX_DLY];
    logic [PIX_DLY-1:0]     von_pipe;
    logic [11:0]            pix_dly;
    logic                   von_dly;

    logic                   start_prev;
    logic                   origin_prev;
    logic                   at_origin;
    logic                   start_edge;
    logic                   frame_tick;

    logic [11:0]            rgb_next;
    logic                   run_next;
    logic                   greset_next;

    logic [11:0]            vga_rgb_q;
    logic                   game_run_q;
    logic                   game_reset_q;

    assign at_origin  = (bus.pix_row == 10'd0) && (bus.pix_col == 10'd0);
    assign start_edge = bus.start_btn && !start_prev;
    assign frame_tick = at_origin && !origin_prev;
    assign pix_dly    = pix_pipe[PIX_DLY-1];
    assign von_dly    = von_pipe[PIX_DLY-1];

    // Delay the game scene and its blanking flag to line up with you_win_pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIX_DLY; i++) begin
                pix_pipe[i] <= 12'h000;
                von_pipe[i] <= 1'b0;
            end
        end else begin
            pix_pipe[0] <= bus.game_pixel;
            von_pipe[0] <= bus.video_on;
            for (int i = 1; i < PIX_DLY; i++) begin
                pix_pipe[i] <= pix_pipe[i-1];
                von_pipe[i] <= von_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_prev  <= 1'b0;
            origin_prev <= 1'b0;
        end else begin
            start_prev  <= bus.start_btn;
            origin_prev <= at_origin;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            frame_cnt <= '0;
        end else begin
            state <= next_state;
            if (cnt_clear) begin
                frame_cnt <= '0;
            end else if (cnt_inc) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // win_flag is only honoured in PLAY so a stale flag cannot leave IDLE.
    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    next_state = PLAY;
                end
            end
            PLAY: begin
                if (bus.win_flag) begin
                    next_state = WIN;
                    cnt_clear  = 1'b1;
                end
            end
            WIN: begin
                if (frame_tick) begin
                    if (frame_cnt == HOLD_LAST) begin
                        next_state = RESTART;
                    end else if (frame_cnt != CNT_MAX) begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            RESTART: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs are decoded from next_state so their registers line up with state_out.
    always_comb begin
        rgb_next    = 12'h000;
        run_next    = (next_state == PLAY);
        greset_next = ((state == IDLE) && (next_state == PLAY)) || (next_state == RESTART);
        if (von_dly) begin
            case (next_state)
                IDLE, PLAY: rgb_next = pix_dly;
                WIN:        rgb_next = bus.you_win_pixel;
                default:    rgb_next = 12'h000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_rgb_q    <= 12'h000;
            game_run_q   <= 1'b0;
            game_reset_q <= 1'b0;
        end else begin
            vga_rgb_q    <= rgb_next;
            game_run_q   <= run_next;
            game_reset_q <= greset_next;
        end
    end

    assign bus.vga_rgb    = vga_rgb_q;
    assign bus.game_run   = game_run_q;
    assign bus.game_reset = game_reset_q;
    assign bus.state_out  = state;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Self-checking bench for game_screen_ctrl: table-driven pixel/flow vectors plus
// hand-written frame-hold, restart and mid-hold reset sequences.
module tb_game_screen_ctrl;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    game_screen_ctrl_if bus ();

    game_screen_ctrl #(
        .PIX_DLY         (3),
        .WIN_HOLD_FRAMES (2),
        .FRAME_CNT_W     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        vo;
        logic [11:0] gp;
        logic [11:0] yw;
        logic        wf;
        logic [11:0] ev;
        logic [1:0]  es;
        logic        er;
        logic        ers;
    } vec_t;

    vec_t vecs [21];

    task automatic applyStimulus(input logic rst, input logic st, input logic [9:0] row,
                                 input logic [9:0] col, input logic vo, input logic [11:0] gp,
                                 input logic [11:0] yw, input logic wf);
        reset             = rst;
        bus.start_btn     = st;
        bus.pix_row       = row;
        bus.pix_col       = col;
        bus.video_on      = vo;
        bus.game_pixel    = gp;
        bus.you_win_pixel = yw;
        bus.win_flag      = wf;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input bit chk_vga, input logic [11:0] ev,
                               input logic [1:0] es, input logic er, input logic ers);
        if (chk_vga) begin
            compared++;
            if (bus.vga_rgb !== ev) begin
                mismatched++;
                $display("[TB] FAIL %s vga_rgb got %h want %h", name, bus.vga_rgb, ev);
            end
        end
        compared++;
        if (bus.state_out !== es) begin
            mismatched++;
            $display("[TB] FAIL %s state_out got %0d want %0d", name, bus.state_out, es);
        end
        compared++;
        if (bus.game_run !== er) begin
            mismatched++;
            $display("[TB] FAIL %s game_run got %b want %b", name, bus.game_run, er);
        end
        compared++;
        if (bus.game_reset !== ers) begin
            mismatched++;
            $display("[TB] FAIL %s game_reset got %b want %b", name, bus.game_reset, ers);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // Expected vga is the game pixel three table rows earlier (or you_win_pixel of the same row in WIN).
        vecs[0]  = '{1'b0, 1'b1, 12'h001, 12'hABC, 1'b1, 12'h000, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 12'h002, 12'h000, 1'b0, 12'h000, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 12'h003, 12'h000, 1'b0, 12'h000, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 12'h004, 12'h000, 1'b0, 12'h001, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 12'h005, 12'h000, 1'b0, 12'h002, 2'd1, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 12'h006, 12'h000, 1'b0, 12'h003, 2'd1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 12'h007, 12'h000, 1'b0, 12'h004, 2'd1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 12'h008, 12'h000, 1'b0, 12'h005, 2'd1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 12'hF00, 12'h000, 1'b0, 12'h006, 2'd1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 12'hF00, 12'h000, 1'b0, 12'h007, 2'd1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 12'hF00, 12'h000, 1'b0, 12'h008, 2'd1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 12'hF00, 12'h000, 1'b0, 12'h000, 2'd1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 12'h0F0, 12'h000, 1'b0, 12'h000, 2'd1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 12'h0F0, 12'h000, 1'b0, 12'hF00, 2'd1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 12'h0F0, 12'h000, 1'b0, 12'hF00, 2'd1, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 12'h00F, 12'hFFF, 1'b1, 12'hFFF, 2'd2, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 12'h00F, 12'h123, 1'b0, 12'h123, 2'd2, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 12'h00F, 12'h456, 1'b0, 12'h456, 2'd2, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 12'h00F, 12'h789, 1'b0, 12'h789, 2'd2, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 12'h00F, 12'hAAA, 1'b0, 12'hAAA, 2'd2, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 12'h00F, 12'hBBB, 1'b0, 12'h000, 2'd2, 1'b0, 1'b0};

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 10'd5, 10'd5, 1'b1, 12'hEEE, 12'hDDD, 1'b0);
        end
        checkOutput("reset", 1'b1, 12'h000, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < 21; i++) begin
            applyStimulus(1'b0, vecs[i].st, 10'd5, 10'd5, vecs[i].vo, vecs[i].gp, vecs[i].yw,
                          vecs[i].wf);
            checkOutput($sformatf("vec%0d", i), 1'b1, vecs[i].ev, vecs[i].es, vecs[i].er,
                        vecs[i].ers);
        end

        // Hold of two frames: a stalled origin must not count twice.
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("tick1", 1'b0, 12'h000, 2'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("stall", 1'b0, 12'h000, 2'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 10'd5, 10'd5, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("midframe", 1'b0, 12'h000, 2'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("restart", 1'b1, 12'h000, 2'd3, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("to_idle", 1'b0, 12'h000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 10'd5, 10'd5, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("idle_a", 1'b0, 12'h000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("tick3", 1'b0, 12'h000, 2'd0, 1'b0, 1'b0);

        // Reset mid-hold, then a fresh win must start counting from zero.
        applyStimulus(1'b0, 1'b1, 10'd5, 10'd5, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("play2", 1'b0, 12'h000, 2'd1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 10'd5, 10'd5, 1'b1, 12'h00F, 12'hBBB, 1'b1);
        checkOutput("win2", 1'b0, 12'h000, 2'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("win2_tick", 1'b0, 12'h000, 2'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 10'd5, 10'd5, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("mid_reset", 1'b1, 12'h000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 10'd5, 10'd5, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("post_reset", 1'b0, 12'h000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 10'd5, 10'd5, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("play3", 1'b0, 12'h000, 2'd1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 10'd5, 10'd5, 1'b1, 12'h00F, 12'hBBB, 1'b1);
        checkOutput("win3", 1'b0, 12'h000, 2'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("win3_tick1", 1'b0, 12'h000, 2'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 10'd5, 10'd5, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("win3_mid", 1'b0, 12'h000, 2'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("win3_restart", 1'b1, 12'h000, 2'd3, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 10'd5, 10'd5, 1'b1, 12'h00F, 12'hBBB, 1'b0);
        checkOutput("win3_idle", 1'b0, 12'h000, 2'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
